// File: rtl/tdma_txdp_dispatcher.sv
// Multi-queue TXDP dispatcher: round-robin grants a pending TX queue, pops its head descriptor,
// writes it to the queue's ath9k TXDP register over IPIC-lite and pushes it back into the FIFO.
module tdma_txdp_dispatcher #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_QUEUES     = 4,
  parameter int unsigned CNT_WIDTH      = 3,
  parameter logic [31:0] ATH9K_BASE     = 32'h6000_0000,
  parameter logic [31:0] TXDP_BASE      = 32'h0000_0800,
  parameter int unsigned TXDP_STRIDE    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_QUEUES-1:0]            send_req,
  input  logic [NUM_QUEUES-1:0]            queue_enable,
  input  logic [5:0]                       desc_irq_state,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] txfifo_dread,
  input  logic [NUM_QUEUES-1:0]            txfifo_valid,
  output logic [NUM_QUEUES-1:0]            txfifo_rd_en,
  output logic [NUM_QUEUES-1:0]            txfifo_wr_start,
  output logic [DATA_WIDTH-1:0]            txfifo_wr_data,
  input  logic [NUM_QUEUES-1:0]            txfifo_wr_done,
  input  logic [3:0]                       curr_ipic_lite_state,
  output logic [2:0]                       ipic_type_lite,
  output logic                             ipic_start_lite,
  input  logic                             ipic_done_lite_wire,
  output logic [ADDR_WIDTH-1:0]            write_addr_lite,
  output logic [DATA_WIDTH-1:0]            write_data_lite,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]  pending_cnt,
  output logic                             busy,
  output logic                             sent_pulse,
  output logic [3:0]                       sent_queue,
  output logic                             overflow_err,
  output logic                             timeout_err
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned SEL_W = 16;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [2:0] IPIC_SINGLE_WR = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_ISSUE, S_WAIT} state_t;

  state_t                          r_state, w_state_nxt;
  logic [NUM_QUEUES*CNT_WIDTH-1:0] r_cnt;
  logic [IDX_W-1:0]                r_rr_ptr, r_gnt;
  logic                            r_ipic_done, r_wr_done;
  logic [TO_W-1:0]                 r_to_cnt;
  logic [NUM_QUEUES-1:0]           r_rd_en, r_wr_start;
  logic [DATA_WIDTH-1:0]           r_wr_data, r_wdata;
  logic [ADDR_WIDTH-1:0]           r_waddr;
  logic [2:0]                      r_type;
  logic                            r_start, r_busy, r_sent, r_ovf, r_to_err;
  logic [3:0]                      r_sent_q;

  logic [SEL_W-1:0]      w_elig, w_wrdone;
  logic [IDX_W:0]        w_cand;
  logic                  w_found;
  logic [IDX_W-1:0]      w_gnt_idx, w_rr_next;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [NUM_QUEUES-1:0] w_gnt_oh, w_cur_oh;
  logic                  w_grant, w_start, w_done_ok, w_timeout, w_both;

  // Eligibility per queue, padded so a 4-bit index always selects in range.
  always_comb begin
    w_elig   = '0;
    w_wrdone = SEL_W'(txfifo_wr_done);
    for (int q = 0; q < NUM_QUEUES; q++) begin
      w_elig[q] = (r_cnt[q*CNT_WIDTH +: CNT_WIDTH] != '0) && queue_enable[q] && txfifo_valid[q];
    end
  end

  // Round-robin scan upward from r_rr_ptr, wrapping at NUM_QUEUES-1.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      w_cand = (IDX_W+1)'(r_rr_ptr) + (IDX_W+1)'(i);
      if (w_cand >= (IDX_W+1)'(NUM_QUEUES)) w_cand = w_cand - (IDX_W+1)'(NUM_QUEUES);
      if (!w_found && w_elig[w_cand[IDX_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (w_gnt_idx == IDX_W'(q)) w_gnt_data = txfifo_dread[q*DATA_WIDTH +: DATA_WIDTH];
    end
    w_gnt_addr = ADDR_WIDTH'(ATH9K_BASE) + ADDR_WIDTH'(TXDP_BASE)
               + ADDR_WIDTH'(w_gnt_idx) * ADDR_WIDTH'(TXDP_STRIDE);
    w_gnt_oh   = NUM_QUEUES'(1) << w_gnt_idx;
    w_cur_oh   = NUM_QUEUES'(1) << r_gnt;
    w_rr_next  = (r_gnt == IDX_W'(NUM_QUEUES - 1)) ? '0 : r_gnt + IDX_W'(1);
    w_both     = (r_ipic_done | ipic_done_lite_wire) & (r_wr_done | w_wrdone[r_gnt]);
  end

  // Next-state logic; w_start schedules the registered start strobe for the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_start     = 1'b0;
    w_done_ok   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (desc_irq_state == 6'd0 && w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_POP;
        end
      end
      S_POP: begin
        w_state_nxt = S_ISSUE;
        if (curr_ipic_lite_state == 4'd0) w_start = 1'b1;
      end
      S_ISSUE: begin
        if (r_start) w_state_nxt = S_WAIT;
        else if (curr_ipic_lite_state == 4'd0) w_start = 1'b1;
      end
      S_WAIT: begin
        if (w_both) begin
          w_done_ok   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_ipic_done <= 1'b0;
      r_wr_done   <= 1'b0;
      r_to_cnt    <= '0;
      r_rd_en     <= '0;
      r_wr_start  <= '0;
      r_wr_data   <= '0;
      r_wdata     <= '0;
      r_waddr     <= '0;
      r_type      <= '0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_sent      <= 1'b0;
      r_sent_q    <= '0;
      r_ovf       <= 1'b0;
      r_to_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (send_req[q] && !(w_grant && w_gnt_oh[q])) begin
          if (r_cnt[q*CNT_WIDTH +: CNT_WIDTH] == CNT_MAX) r_ovf <= 1'b1;
          else r_cnt[q*CNT_WIDTH +: CNT_WIDTH] <= r_cnt[q*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
        end else if (!send_req[q] && w_grant && w_gnt_oh[q]) begin
          r_cnt[q*CNT_WIDTH +: CNT_WIDTH] <= r_cnt[q*CNT_WIDTH +: CNT_WIDTH] - CNT_WIDTH'(1);
        end
      end
      r_rd_en    <= w_grant ? w_gnt_oh : '0;
      r_start    <= w_start;
      r_wr_start <= w_start ? w_cur_oh : '0;
      if (w_grant) begin
        r_gnt     <= w_gnt_idx;
        r_wdata   <= w_gnt_data;
        r_wr_data <= w_gnt_data;
        r_waddr   <= w_gnt_addr;
        r_type    <= IPIC_SINGLE_WR;
      end
      // Completion flags also latch during the start cycle so an immediate reply is not lost.
      if (w_start) begin
        r_ipic_done <= 1'b0;
        r_wr_done   <= 1'b0;
        r_to_cnt    <= '0;
      end else if (r_start || r_state == S_WAIT) begin
        if (ipic_done_lite_wire) r_ipic_done <= 1'b1;
        if (w_wrdone[r_gnt])     r_wr_done   <= 1'b1;
        if (r_state == S_WAIT)   r_to_cnt    <= r_to_cnt + TO_W'(1);
      end
      r_sent <= w_done_ok;
      if (w_done_ok) r_sent_q <= r_gnt;
      if (w_done_ok || w_timeout) r_rr_ptr <= w_rr_next;
      if (w_timeout) r_to_err <= 1'b1;
    end
  end

  assign txfifo_rd_en    = r_rd_en;
  assign txfifo_wr_start = r_wr_start;
  assign txfifo_wr_data  = r_wr_data;
  assign ipic_type_lite  = r_type;
  assign ipic_start_lite = r_start;
  assign write_addr_lite = r_waddr;
  assign write_data_lite = r_wdata;
  assign pending_cnt     = r_cnt;
  assign busy            = r_busy;
  assign sent_pulse      = r_sent;
  assign sent_queue      = r_sent_q;
  assign overflow_err    = r_ovf;
  assign timeout_err     = r_to_err;

endmodule

// File: tb/tb_tdma_txdp_dispatcher.sv
// Directed bench for tdma_txdp_dispatcher: grant path, round-robin, saturation, gating,
// completion ordering, timeout and mid-transaction reset.
module tb_tdma_txdp_dispatcher;

  localparam int unsigned NQ = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NQ-1:0]     send_req, queue_enable, txfifo_valid, txfifo_rd_en, txfifo_wr_start, txfifo_wr_done;
  logic [5:0]        desc_irq_state;
  logic [NQ*DW-1:0]  txfifo_dread;
  logic [DW-1:0]     txfifo_wr_data, write_data_lite;
  logic [3:0]        curr_ipic_lite_state, sent_queue;
  logic [2:0]        ipic_type_lite;
  logic              ipic_start_lite, ipic_done_lite_wire, busy, sent_pulse, overflow_err, timeout_err;
  logic [AW-1:0]     write_addr_lite;
  logic [NQ*CW-1:0]  pending_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tdma_txdp_dispatcher dut (
    .clk(clk), .reset_n(reset_n), .send_req(send_req), .queue_enable(queue_enable),
    .desc_irq_state(desc_irq_state), .txfifo_dread(txfifo_dread), .txfifo_valid(txfifo_valid),
    .txfifo_rd_en(txfifo_rd_en), .txfifo_wr_start(txfifo_wr_start), .txfifo_wr_data(txfifo_wr_data),
    .txfifo_wr_done(txfifo_wr_done), .curr_ipic_lite_state(curr_ipic_lite_state),
    .ipic_type_lite(ipic_type_lite), .ipic_start_lite(ipic_start_lite),
    .ipic_done_lite_wire(ipic_done_lite_wire), .write_addr_lite(write_addr_lite),
    .write_data_lite(write_data_lite), .pending_cnt(pending_cnt), .busy(busy),
    .sent_pulse(sent_pulse), .sent_queue(sent_queue), .overflow_err(overflow_err),
    .timeout_err(timeout_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    send_req = '0;
    txfifo_wr_done = '0;
    ipic_done_lite_wire = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  task automatic wait_rd(output logic [NQ-1:0] seen, output bit ok);
    ok = 1'b0;
    seen = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (txfifo_rd_en != '0) begin
        ok = 1'b1;
        seen = txfifo_rd_en;
      end else tick;
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (ipic_start_lite) ok = 1'b1;
      else tick;
    end
  endtask

  // From a granted transaction: wait for start, answer both completions together, await sent_pulse.
  task automatic finish_txn(input logic [NQ-1:0] oh, output bit ok, output logic [3:0] q);
    bit st;
    ok = 1'b0;
    q = '0;
    wait_start(st);
    if (st) begin
      tick;
      ipic_done_lite_wire = 1'b1;
      txfifo_wr_done = oh;
      tick;
      ipic_done_lite_wire = 1'b0;
      txfifo_wr_done = '0;
      for (int i = 0; i < 10 && !ok; i++) begin
        if (sent_pulse) begin
          ok = 1'b1;
          q = sent_queue;
        end else tick;
      end
    end
  endtask

  task automatic test_reset;
    do_reset;
    total++;
    if ({busy, sent_pulse, ipic_start_lite, overflow_err, timeout_err} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {busy, sent_pulse, ipic_start_lite, overflow_err, timeout_err});
    end
    total++;
    if ({txfifo_rd_en, txfifo_wr_start, ipic_type_lite, pending_cnt} !== '0) begin
      bad++; $display("FAIL reset_vectors rd=%b wrs=%b type=%0d pend=%h", txfifo_rd_en, txfifo_wr_start, ipic_type_lite, pending_cnt);
    end
    total++;
    if ({write_addr_lite, write_data_lite, txfifo_wr_data} !== '0) begin
      bad++; $display("FAIL reset_data addr=%h data=%h wrdata=%h", write_addr_lite, write_data_lite, txfifo_wr_data);
    end
  endtask

  task automatic test_single;
    send_req = 4'b0010;
    tick;
    send_req = '0;
    total++;
    if (pending_cnt !== 12'h008) begin bad++; $display("FAIL single_pend_inc got=%h exp=008", pending_cnt); end
    tick;
    total++;
    if (txfifo_rd_en !== 4'b0010 || busy !== 1'b1 || ipic_type_lite !== 3'd3) begin
      bad++; $display("FAIL single_grant rd=%b busy=%b type=%0d exp rd=0010 busy=1 type=3", txfifo_rd_en, busy, ipic_type_lite);
    end
    total++;
    if (write_addr_lite !== 32'h6000_0804 || write_data_lite !== 32'hA000_0040 || txfifo_wr_data !== 32'hA000_0040) begin
      bad++; $display("FAIL single_addr_data addr=%h data=%h wrdata=%h exp 60000804/A0000040", write_addr_lite, write_data_lite, txfifo_wr_data);
    end
    total++;
    if (pending_cnt !== 12'h000) begin bad++; $display("FAIL single_pend_dec got=%h exp=000", pending_cnt); end
    tick;
    total++;
    if (txfifo_rd_en !== 4'b0000 || ipic_start_lite !== 1'b1 || txfifo_wr_start !== 4'b0010) begin
      bad++; $display("FAIL single_start rd=%b start=%b wrs=%b exp 0000/1/0010", txfifo_rd_en, ipic_start_lite, txfifo_wr_start);
    end
    tick;
    total++;
    if (ipic_start_lite !== 1'b0 || txfifo_wr_start !== 4'b0000) begin
      bad++; $display("FAIL single_start_width start=%b wrs=%b exp 0/0000", ipic_start_lite, txfifo_wr_start);
    end
    ipic_done_lite_wire = 1'b1;
    txfifo_wr_done = 4'b0010;
    tick;
    ipic_done_lite_wire = 1'b0;
    txfifo_wr_done = '0;
    total++;
    if (sent_pulse !== 1'b1 || sent_queue !== 4'd1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_sent pulse=%b q=%0d busy=%b exp 1/1/0", sent_pulse, sent_queue, busy);
    end
    tick;
    total++;
    if (sent_pulse !== 1'b0) begin bad++; $display("FAIL single_sent_width got=%b exp=0", sent_pulse); end
  endtask

  task automatic test_round_robin;
    logic [NQ-1:0] exp_oh [6];
    logic [NQ-1:0] seen;
    logic [3:0]    q;
    bit            ok1, ok2;
    exp_oh[0] = 4'b0001; exp_oh[1] = 4'b0100; exp_oh[2] = 4'b1000;
    exp_oh[3] = 4'b0001; exp_oh[4] = 4'b0100; exp_oh[5] = 4'b1000;
    do_reset;
    queue_enable = 4'b0000;
    send_req = 4'b1101;
    tick;
    tick;
    send_req = '0;
    total++;
    if (pending_cnt !== 12'h482) begin bad++; $display("FAIL rr_load got=%h exp=482", pending_cnt); end
    queue_enable = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_rd(seen, ok1);
      finish_txn(seen, ok2, q);
      total++;
      if (!ok1 || !ok2 || seen !== exp_oh[k]) begin
        bad++; $display("FAIL rr_grant%0d got=%b exp=%b rd_ok=%0d done_ok=%0d", k, seen, exp_oh[k], ok1, ok2);
      end
    end
    tick;
    total++;
    if (pending_cnt !== 12'h000) begin bad++; $display("FAIL rr_drain got=%h exp=000", pending_cnt); end
  endtask

  task automatic test_saturation;
    bit         ok;
    logic [3:0] q;
    do_reset;
    queue_enable = 4'b1110;
    send_req = 4'b0001;
    for (int i = 0; i < 8; i++) tick;
    send_req = '0;
    total++;
    if (pending_cnt[2:0] !== 3'd7 || overflow_err !== 1'b1) begin
      bad++; $display("FAIL sat_max pend=%0d ovf=%b exp 7/1", pending_cnt[2:0], overflow_err);
    end
    queue_enable = 4'b1111;
    send_req = 4'b0001;
    tick;
    send_req = '0;
    queue_enable = 4'b1110;
    total++;
    if (pending_cnt[2:0] !== 3'd7 || txfifo_rd_en !== 4'b0001) begin
      bad++; $display("FAIL sat_req_and_grant pend=%0d rd=%b exp 7/0001", pending_cnt[2:0], txfifo_rd_en);
    end
    finish_txn(4'b0001, ok, q);
    tick;
    total++;
    if (!ok || q !== 4'd0 || busy !== 1'b0 || pending_cnt[2:0] !== 3'd7) begin
      bad++; $display("FAIL sat_enable_drop ok=%0d q=%0d busy=%b pend=%0d exp 1/0/0/7", ok, q, busy, pending_cnt[2:0]);
    end
    queue_enable = 4'b1111;
  endtask

  task automatic test_gating;
    logic       any;
    bit         ok;
    logic [3:0] q;
    do_reset;
    desc_irq_state = 6'd5;
    send_req = 4'b0100;
    tick;
    send_req = '0;
    any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      any = any | busy | (|txfifo_rd_en);
    end
    total++;
    if (any !== 1'b0) begin bad++; $display("FAIL gate_irq_block got=%b exp=0", any); end
    desc_irq_state = 6'd0;
    curr_ipic_lite_state = 4'd2;
    tick;
    desc_irq_state = 6'd5;
    total++;
    if (txfifo_rd_en !== 4'b0100 || write_addr_lite !== 32'h6000_0808 || write_data_lite !== 32'hC000_0080) begin
      bad++; $display("FAIL gate_release rd=%b addr=%h data=%h exp 0100/60000808/C0000080", txfifo_rd_en, write_addr_lite, write_data_lite);
    end
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      any = any | ipic_start_lite | (|txfifo_wr_start);
    end
    total++;
    if (any !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL gate_ipic_hold start_seen=%b busy=%b exp 0/1", any, busy); end
    curr_ipic_lite_state = 4'd0;
    tick;
    total++;
    if (ipic_start_lite !== 1'b1 || txfifo_wr_start !== 4'b0100) begin
      bad++; $display("FAIL gate_ipic_issue start=%b wrs=%b exp 1/0100", ipic_start_lite, txfifo_wr_start);
    end
    finish_txn(4'b0100, ok, q);
    total++;
    if (!ok || q !== 4'd2) begin bad++; $display("FAIL gate_complete ok=%0d q=%0d exp 1/2", ok, q); end
    desc_irq_state = 6'd0;
  endtask

  task automatic test_order_timeout;
    logic [NQ-1:0] seen;
    bit            ok1, ok2;
    int            pulses;
    do_reset;
    send_req = 4'b1000;
    tick;
    send_req = '0;
    wait_rd(seen, ok1);
    wait_start(ok2);
    tick;
    txfifo_wr_done = 4'b1000;
    tick;
    txfifo_wr_done = '0;
    pulses = (sent_pulse === 1'b1) ? 1 : 0;
    tick;
    pulses += (sent_pulse === 1'b1) ? 1 : 0;
    tick;
    ipic_done_lite_wire = 1'b1;
    pulses += (sent_pulse === 1'b1) ? 1 : 0;
    tick;
    ipic_done_lite_wire = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pulses += (sent_pulse === 1'b1) ? 1 : 0;
      tick;
    end
    total++;
    if (!ok1 || !ok2 || pulses != 1 || sent_queue !== 4'd3) begin
      bad++; $display("FAIL order_wrdone_first pulses=%0d q=%0d exp 1/3 rd_ok=%0d st_ok=%0d", pulses, sent_queue, ok1, ok2);
    end
    send_req = 4'b1000;
    tick;
    send_req = '0;
    wait_rd(seen, ok1);
    wait_start(ok2);
    tick;
    txfifo_wr_done = 4'b1000;
    tick;
    txfifo_wr_done = '0;
    pulses = 0;
    for (int i = 0; i < 990; i++) begin
      pulses += (sent_pulse === 1'b1) ? 1 : 0;
      tick;
    end
    total++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL timeout_early busy=%b terr=%b exp 1/0", busy, timeout_err);
    end
    for (int i = 0; i < 60 && busy; i++) begin
      pulses += (sent_pulse === 1'b1) ? 1 : 0;
      tick;
    end
    pulses += (sent_pulse === 1'b1) ? 1 : 0;
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || pulses != 0) begin
      bad++; $display("FAIL timeout_fire busy=%b terr=%b pulses=%0d exp 0/1/0", busy, timeout_err, pulses);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [NQ-1:0] seen;
    bit            ok1, ok2;
    logic          any;
    queue_enable = 4'b1011;
    send_req = 4'b0100;
    for (int i = 0; i < 8; i++) tick;
    send_req = 4'b0010;
    tick;
    send_req = '0;
    wait_rd(seen, ok1);
    wait_start(ok2);
    tick;
    total++;
    if (!ok1 || !ok2 || seen !== 4'b0010 || overflow_err !== 1'b1 || timeout_err !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL midwait_setup rd=%b ovf=%b terr=%b busy=%b exp 0010/1/1/1", seen, overflow_err, timeout_err, busy);
    end
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    total++;
    if ({busy, ipic_start_lite, sent_pulse, overflow_err, timeout_err, txfifo_rd_en, txfifo_wr_start} !== '0 || pending_cnt !== '0) begin
      bad++; $display("FAIL midwait_reset busy=%b st=%b sent=%b ovf=%b terr=%b rd=%b wrs=%b pend=%h",
                      busy, ipic_start_lite, sent_pulse, overflow_err, timeout_err, txfifo_rd_en, txfifo_wr_start, pending_cnt);
    end
    any = 1'b0;
    ipic_done_lite_wire = 1'b1;
    txfifo_wr_done = 4'b0010;
    tick;
    ipic_done_lite_wire = 1'b0;
    txfifo_wr_done = '0;
    for (int i = 0; i < 4; i++) begin
      any = any | sent_pulse | busy;
      tick;
    end
    total++;
    if (any !== 1'b0) begin bad++; $display("FAIL midwait_quiet got=%b exp=0", any); end
    queue_enable = 4'b1111;
  endtask

  initial begin
    reset_n = 1'b0;
    send_req = '0;
    queue_enable = 4'b1111;
    txfifo_valid = 4'b1111;
    desc_irq_state = 6'd0;
    curr_ipic_lite_state = 4'd0;
    ipic_done_lite_wire = 1'b0;
    txfifo_wr_done = '0;
    txfifo_dread = {32'h1234_5678, 32'hC000_0080, 32'hA000_0040, 32'hB000_0000};
    test_reset;
    test_single;
    test_round_robin;
    test_saturation;
    test_gating;
    test_order_timeout;
    test_reset_mid_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
